// File: rtl/lsu.sv
// Load/store stage: takes one instruction from EX, performs at most one data-memory access over a
// valid/ready request channel plus a response channel, aligns load data, raises misaligned and
// access-fault traps, and registers the result for write-back.
module lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        EX_LS_reg_execute_valid_i,
    output logic        LS_EX_ls_ready_o,
    input  logic        EX_LS_reg_load_i,
    input  logic        EX_LS_reg_store_i,
    input  logic [2:0]  EX_LS_reg_funct3_i,
    input  logic [63:0] EX_LS_reg_data_i,
    input  logic [63:0] EX_LS_reg_store_data_i,
    input  logic [63:0] EX_LS_reg_PC_i,
    input  logic [63:0] EX_LS_reg_next_PC_i,
    input  logic [31:0] EX_LS_reg_inst_i,
    input  logic [4:0]  EX_LS_reg_rd_i,
    input  logic        EX_LS_reg_dest_wen_i,
    input  logic        EX_LS_reg_trap_valid_i,
    input  logic [63:0] EX_LS_reg_trap_cause_i,
    input  logic [63:0] EX_LS_reg_trap_tval_i,
    input  logic [16:0] EX_LS_reg_misc_i,
    output logic        LS_WB_reg_ls_valid_o,
    output logic [63:0] LS_WB_reg_data_o,
    output logic [63:0] LS_WB_reg_PC_o,
    output logic [63:0] LS_WB_reg_next_PC_o,
    output logic [31:0] LS_WB_reg_inst_o,
    output logic [4:0]  LS_WB_reg_rd_o,
    output logic        LS_WB_reg_dest_wen_o,
    output logic        LS_WB_reg_trap_valid_o,
    output logic [63:0] LS_WB_reg_trap_cause_o,
    output logic [63:0] LS_WB_reg_trap_tval_o,
    output logic [16:0] LS_WB_reg_misc_o,
    input  logic        WB_LS_ls_ready_i,
    input  logic        WB_LS_flush_flag_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_req_addr_o,
    output logic        mem_req_wen_o,
    output logic [63:0] mem_req_wdata_o,
    output logic [7:0]  mem_req_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [63:0] mem_rsp_rdata_i,
    input  logic        mem_rsp_err_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q;
    logic        kill_q, req_valid_q, store_q, dwen_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q, sdata_q, pc_q, npc_q;
    logic [31:0] inst_q;
    logic [4:0]  rd_q;
    logic [16:0] misc_q;

    logic        out_valid_q, out_dwen_q, out_trap_q;
    logic [63:0] out_data_q, out_pc_q, out_npc_q, out_cause_q, out_tval_q;
    logic [31:0] out_inst_q;
    logic [4:0]  out_rd_q;
    logic [16:0] out_misc_q;

    logic        out_free, accept, is_mem, misaligned;
    logic [63:0] load_sh, load_ext;
    logic [7:0]  strb_base;

    // Handshake, alignment check, load extension and store lane placement.
    always_comb begin
        out_free   = !out_valid_q || WB_LS_ls_ready_i;
        accept     = (state_q == StIdle) && !WB_LS_flush_flag_i && out_free;
        is_mem     = EX_LS_reg_load_i || EX_LS_reg_store_i;
        misaligned = 1'b0;
        unique case (EX_LS_reg_funct3_i[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = EX_LS_reg_data_i[0];
            2'd2:    misaligned = |EX_LS_reg_data_i[1:0];
            default: misaligned = |EX_LS_reg_data_i[2:0];
        endcase
        load_sh  = mem_rsp_rdata_i >> {addr_q[2:0], 3'b000};
        load_ext = load_sh;
        unique case (funct3_q)
            3'b000:  load_ext = {{56{load_sh[7]}}, load_sh[7:0]};
            3'b001:  load_ext = {{48{load_sh[15]}}, load_sh[15:0]};
            3'b010:  load_ext = {{32{load_sh[31]}}, load_sh[31:0]};
            3'b100:  load_ext = {56'd0, load_sh[7:0]};
            3'b101:  load_ext = {48'd0, load_sh[15:0]};
            3'b110:  load_ext = {32'd0, load_sh[31:0]};
            default: load_ext = load_sh;
        endcase
        strb_base = 8'hFF;
        unique case (funct3_q[1:0])
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    assign LS_EX_ls_ready_o = accept;
    assign mem_req_valid_o  = req_valid_q;
    assign mem_req_addr_o   = {addr_q[63:3], 3'b000};
    assign mem_req_wen_o    = store_q;
    assign mem_req_wdata_o  = sdata_q << {addr_q[2:0], 3'b000};
    assign mem_req_wstrb_o  = strb_base << addr_q[2:0];

    assign LS_WB_reg_ls_valid_o   = out_valid_q;
    assign LS_WB_reg_data_o       = out_data_q;
    assign LS_WB_reg_PC_o         = out_pc_q;
    assign LS_WB_reg_next_PC_o    = out_npc_q;
    assign LS_WB_reg_inst_o       = out_inst_q;
    assign LS_WB_reg_rd_o         = out_rd_q;
    assign LS_WB_reg_dest_wen_o   = out_dwen_q;
    assign LS_WB_reg_trap_valid_o = out_trap_q;
    assign LS_WB_reg_trap_cause_o = out_cause_q;
    assign LS_WB_reg_trap_tval_o  = out_tval_q;
    assign LS_WB_reg_misc_o       = out_misc_q;

    // Access FSM together with the LS/WB output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 64'd0;
            sdata_q     <= 64'd0;
            pc_q        <= 64'd0;
            npc_q       <= 64'd0;
            inst_q      <= 32'd0;
            rd_q        <= 5'd0;
            dwen_q      <= 1'b0;
            misc_q      <= 17'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            out_pc_q    <= 64'd0;
            out_npc_q   <= 64'd0;
            out_inst_q  <= 32'd0;
            out_rd_q    <= 5'd0;
            out_dwen_q  <= 1'b0;
            out_trap_q  <= 1'b0;
            out_cause_q <= 64'd0;
            out_tval_q  <= 64'd0;
            out_misc_q  <= 17'd0;
        end else begin
            if (WB_LS_flush_flag_i || out_free) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept && EX_LS_reg_execute_valid_i) begin
                        if (EX_LS_reg_trap_valid_i || !is_mem || misaligned) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= EX_LS_reg_data_i;
                            out_pc_q    <= EX_LS_reg_PC_i;
                            out_npc_q   <= EX_LS_reg_next_PC_i;
                            out_inst_q  <= EX_LS_reg_inst_i;
                            out_rd_q    <= EX_LS_reg_rd_i;
                            out_dwen_q  <= EX_LS_reg_dest_wen_i;
                            out_misc_q  <= EX_LS_reg_misc_i;
                            if (EX_LS_reg_trap_valid_i) begin
                                out_trap_q  <= 1'b1;
                                out_cause_q <= EX_LS_reg_trap_cause_i;
                                out_tval_q  <= EX_LS_reg_trap_tval_i;
                            end else if (is_mem) begin
                                out_trap_q  <= 1'b1;
                                out_cause_q <= EX_LS_reg_store_i ? 64'd6 : 64'd4;
                                out_tval_q  <= EX_LS_reg_data_i;
                            end else begin
                                out_trap_q  <= 1'b0;
                                out_cause_q <= 64'd0;
                                out_tval_q  <= 64'd0;
                            end
                        end else begin
                            // Accepting implies the output register drains this edge, so a
                            // store never has to wait for it and the request rises at once.
                            state_q     <= StReq;
                            req_valid_q <= 1'b1;
                            store_q     <= EX_LS_reg_store_i;
                            funct3_q    <= EX_LS_reg_funct3_i;
                            addr_q      <= EX_LS_reg_data_i;
                            sdata_q     <= EX_LS_reg_store_data_i;
                            pc_q        <= EX_LS_reg_PC_i;
                            npc_q       <= EX_LS_reg_next_PC_i;
                            inst_q      <= EX_LS_reg_inst_i;
                            rd_q        <= EX_LS_reg_rd_i;
                            dwen_q      <= EX_LS_reg_dest_wen_i;
                            misc_q      <= EX_LS_reg_misc_i;
                        end
                    end
                end
                StReq: begin
                    // A raised request must complete; a flush only marks it killed.
                    if (WB_LS_flush_flag_i) kill_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rsp_valid_i) begin
                        state_q <= StIdle;
                        kill_q  <= 1'b0;
                        // The output register is always empty here (drained at accept).
                        if (!kill_q && !WB_LS_flush_flag_i) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= store_q ? addr_q : load_ext;
                            out_pc_q    <= pc_q;
                            out_npc_q   <= npc_q;
                            out_inst_q  <= inst_q;
                            out_rd_q    <= rd_q;
                            out_dwen_q  <= dwen_q;
                            out_misc_q  <= misc_q;
                            out_trap_q  <= mem_rsp_err_i;
                            out_cause_q <= mem_rsp_err_i ? (store_q ? 64'd7 : 64'd5) : 64'd0;
                            out_tval_q  <= mem_rsp_err_i ? addr_q : 64'd0;
                        end
                    end else if (WB_LS_flush_flag_i) begin
                        kill_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store stage.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid, ls_ready, ex_load, ex_store, ex_dwen, ex_trap;
    logic [2:0]  ex_f3;
    logic [63:0] ex_data, ex_sdata, ex_pc, ex_npc, ex_cause, ex_tval;
    logic [31:0] ex_inst;
    logic [4:0]  ex_rd;
    logic [16:0] ex_misc;
    logic        wb_valid, wb_dwen, wb_trap;
    logic [63:0] wb_data, wb_pc, wb_npc, wb_cause, wb_tval;
    logic [31:0] wb_inst;
    logic [4:0]  wb_rd;
    logic [16:0] wb_misc;
    logic        wb_ready, flush;
    logic        req_valid, req_ready, req_wen, rsp_valid, rsp_err;
    logic [63:0] req_addr, req_wdata, rsp_rdata;
    logic [7:0]  req_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lsu dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .EX_LS_reg_execute_valid_i(ex_valid),
        .LS_EX_ls_ready_o         (ls_ready),
        .EX_LS_reg_load_i         (ex_load),
        .EX_LS_reg_store_i        (ex_store),
        .EX_LS_reg_funct3_i       (ex_f3),
        .EX_LS_reg_data_i         (ex_data),
        .EX_LS_reg_store_data_i   (ex_sdata),
        .EX_LS_reg_PC_i           (ex_pc),
        .EX_LS_reg_next_PC_i      (ex_npc),
        .EX_LS_reg_inst_i         (ex_inst),
        .EX_LS_reg_rd_i           (ex_rd),
        .EX_LS_reg_dest_wen_i     (ex_dwen),
        .EX_LS_reg_trap_valid_i   (ex_trap),
        .EX_LS_reg_trap_cause_i   (ex_cause),
        .EX_LS_reg_trap_tval_i    (ex_tval),
        .EX_LS_reg_misc_i         (ex_misc),
        .LS_WB_reg_ls_valid_o     (wb_valid),
        .LS_WB_reg_data_o         (wb_data),
        .LS_WB_reg_PC_o           (wb_pc),
        .LS_WB_reg_next_PC_o      (wb_npc),
        .LS_WB_reg_inst_o         (wb_inst),
        .LS_WB_reg_rd_o           (wb_rd),
        .LS_WB_reg_dest_wen_o     (wb_dwen),
        .LS_WB_reg_trap_valid_o   (wb_trap),
        .LS_WB_reg_trap_cause_o   (wb_cause),
        .LS_WB_reg_trap_tval_o    (wb_tval),
        .LS_WB_reg_misc_o         (wb_misc),
        .WB_LS_ls_ready_i         (wb_ready),
        .WB_LS_flush_flag_i       (flush),
        .mem_req_valid_o          (req_valid),
        .mem_req_ready_i          (req_ready),
        .mem_req_addr_o           (req_addr),
        .mem_req_wen_o            (req_wen),
        .mem_req_wdata_o          (req_wdata),
        .mem_req_wstrb_o          (req_wstrb),
        .mem_rsp_valid_i          (rsp_valid),
        .mem_rsp_rdata_i          (rsp_rdata),
        .mem_rsp_err_i            (rsp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction to EX for a single cycle.
    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_f3 = f3;
        ex_data = addr; ex_sdata = sd;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_trap = 1'b0;
    endtask

    // Best-case access: accept t0, handshake t1, response t2; returns at t3.
    task automatic mem_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sd,
                          input logic [63:0] rdata, input logic err,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        drive(~st, st, f3, addr, sd);
        req_ready = 1'b1;
        #1 chk({tag, "_ready"}, ls_ready, 1);
        step();
        idle_ex();
        #1;
        chk({tag, "_req_valid"}, req_valid, 1);
        chk({tag, "_req_addr"}, req_addr, {addr[63:3], 3'b000});
        chk({tag, "_req_wen"}, req_wen, st);
        if (st) begin
            chk({tag, "_wdata"}, req_wdata, exp_wdata);
            chk({tag, "_wstrb"}, req_wstrb, exp_wstrb);
        end
        step();
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
        #1 chk({tag, "_not_early"}, wb_valid, 0);
        step();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        #1 chk({tag, "_ls_valid"}, wb_valid, 1);
    endtask

    initial begin
        rst_ni = 1'b0;
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_f3 = 0; ex_data = 0; ex_sdata = 0;
        ex_pc = 0; ex_npc = 0; ex_inst = 0; ex_rd = 0; ex_dwen = 0; ex_trap = 0;
        ex_cause = 0; ex_tval = 0; ex_misc = 0;
        wb_ready = 1; flush = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
        #12;
        chk("rst_ls_valid", wb_valid, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_trap", wb_trap, 0);
        rst_ni = 1'b1;
        step();
        chk("rst_ready", ls_ready, 1);

        // ld 0x1000 with pass-through fields.
        ex_pc = 64'h80; ex_npc = 64'h84; ex_inst = 32'h0000_3003; ex_rd = 5'd3; ex_dwen = 1;
        ex_misc = 17'h1_2345;
        mem_op("ld", 0, 3'b011, 64'h1000, 0, 64'h8877665544332211, 0, 0, 0);
        chk("ld_data", wb_data, 64'h8877665544332211);
        chk("ld_pc", wb_pc, 64'h80);
        chk("ld_npc", wb_npc, 64'h84);
        chk("ld_rd", wb_rd, 5'd3);
        chk("ld_misc", wb_misc, 17'h1_2345);
        chk("ld_trap", wb_trap, 0);
        step();
        chk("ld_drained", wb_valid, 0);

        // lb 0x1003 and lh 0x1006.
        mem_op("lb", 0, 3'b000, 64'h1003, 0, 64'h8877665544332211, 0, 0, 0);
        chk("lb_data", wb_data, 64'h44);
        step();
        mem_op("lh", 0, 3'b001, 64'h1006, 0, 64'h8877665544332211, 0, 0, 0);
        chk("lh_data", wb_data, 64'hFFFF_FFFF_FFFF_8877);
        step();
        mem_op("lbu", 0, 3'b100, 64'h1007, 0, 64'h8877665544332211, 0, 0, 0);
        chk("lbu_data", wb_data, 64'h88);
        step();

        // sw 0x1004.
        mem_op("sw", 1, 3'b010, 64'h1004, 64'hDEADBEEF, 0, 0, 64'hDEADBEEF_0000_0000, 8'hF0);
        chk("sw_data", wb_data, 64'h1004);
        chk("sw_trap", wb_trap, 0);
        step();

        // lw 0x1002 misaligned: no access, trap at latency 1.
        drive(1, 0, 3'b010, 64'h1002, 0);
        #1 chk("mis_ready", ls_ready, 1);
        step();
        idle_ex();
        #1;
        chk("mis_req_valid", req_valid, 0);
        chk("mis_ls_valid", wb_valid, 1);
        chk("mis_trap", wb_trap, 1);
        chk("mis_cause", wb_cause, 4);
        chk("mis_tval", wb_tval, 64'h1002);
        chk("mis_idle", ls_ready, 1);
        step();

        // Non-memory op passes through with latency 1.
        drive(0, 0, 3'b000, 64'h1234, 0);
        ex_rd = 5'd5;
        step();
        idle_ex();
        #1;
        chk("alu_valid", wb_valid, 1);
        chk("alu_data", wb_data, 64'h1234);
        chk("alu_rd", wb_rd, 5'd5);
        chk("alu_req", req_valid, 0);
        step();

        // Upstream trap on a load suppresses the access and is forwarded.
        drive(1, 0, 3'b011, 64'h3000, 0);
        ex_trap = 1; ex_cause = 64'd2; ex_tval = 64'hABC;
        step();
        idle_ex();
        #1;
        chk("up_req", req_valid, 0);
        chk("up_cause", wb_cause, 2);
        chk("up_tval", wb_tval, 64'hABC);
        step();

        // ld killed by a flush in WAIT; response arrives 3 cycles later.
        drive(1, 0, 3'b011, 64'h1000, 0);
        req_ready = 1;
        step();
        idle_ex();
        step();
        flush = 1;
        #1 chk("fl_ready_wait", ls_ready, 0);
        step();
        flush = 0;
        step();
        #1 chk("fl_still_wait", ls_ready, 0);
        step();
        rsp_valid = 1; rsp_rdata = 64'h1111;
        step();
        rsp_valid = 0;
        #1;
        chk("fl_no_output", wb_valid, 0);
        chk("fl_ready_back", ls_ready, 1);
        step();
        chk("fl_no_output2", wb_valid, 0);

        // sd 0x2000 with access error; WB stalled holds the trap.
        wb_ready = 0;
        mem_op("sd", 1, 3'b011, 64'h2000, 64'h1122334455667788, 0, 1,
               64'h1122334455667788, 8'hFF);
        chk("sd_trap", wb_trap, 1);
        chk("sd_cause", wb_cause, 7);
        chk("sd_tval", wb_tval, 64'h2000);
        chk("sd_stall_ready", ls_ready, 0);
        step();
        chk("sd_hold_valid", wb_valid, 1);
        chk("sd_hold_cause", wb_cause, 7);
        wb_ready = 1;
        step();
        chk("sd_drained", wb_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
